store_buffer: RTL and testbench

- Posted-write FIFO between the MEM-stage store path and the data memory.
- Accepts word stores (address, data, PC) from the pipeline in one cycle, then drains them in order to the data memory write port, one per cycle.
- Forwards buffered store data to loads that hit a pending address, so the memory image seen by loads stays sequentially consistent.
- The pipeline uses `empty` as a sync point, e.g. before halt or an end-of-test memory dump.

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 96 +++++++++
 tb/tb_store_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Pipeline-side bundle for the store buffer: store push, load lookup, drain port to data memory.
// The master side belongs to the pipeline/memory; the slave side belongs to the buffer.
interface store_buffer_if;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;

    logic        hold;
    logic        dm_we;
    logic [31:0] dm_a;
    logic [31:0] dm_din;
    logic [31:0] dm_pc;
    logic        empty;

    modport master (
        output st_req, st_addr, st_data, st_pc, ld_req, ld_addr, hold,
        input  st_ready, ld_hit, ld_data, dm_we, dm_a, dm_din, dm_pc, empty
    );

    modport slave (
        input  st_req, st_addr, st_data, st_pc, ld_req, ld_addr, hold,
        output st_ready, ld_hit, ld_data, dm_we, dm_a, dm_din, dm_pc, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of word stores drained to data memory one per cycle,
// with youngest-match forwarding of pending store data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(DEPTH);

    entry_t            mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTRW-1:0]   head;
    logic [PTRW-1:0]   tail;
    logic [PTRW:0]     count;

    logic              push;
    logic              pop;
    logic [PTRW-1:0]   idx;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    // Word granularity: the byte offset of a load never affects matching.
    wire unused_ld_offset = &{1'b0, bus.ld_addr[1:0]};

    // Ready is derived from registered occupancy only, so a full buffer never
    // accepts a store even in a cycle where it is also popping.
    assign bus.st_ready = (count != FULL_COUNT);
    assign bus.empty    = (count == '0);
    assign bus.dm_we    = !bus.empty && !bus.hold;
    assign bus.dm_a     = mem[head].addr;
    assign bus.dm_din   = mem[head].data;
    assign bus.dm_pc    = mem[head].pc;

    assign push = bus.st_req && bus.st_ready;
    assign pop  = bus.dm_we;

    // Walk oldest to youngest so the last match is the youngest pending store.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTRW'(i);
            if (valid[idx] && (mem[idx].addr[31:2] == bus.ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[idx].data;
            end
        end
    end

    assign bus.ld_hit  = bus.ld_req && fwd_hit;
    assign bus.ld_data = bus.ld_hit ? fwd_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            // NOTE: the entry array is reset too, because the drain port shows the
            // head entry and must read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register
            // samples pre-edge values, including the same-edge push and pop.
            if (push) begin
                mem[tail]   <= '{addr: bus.st_addr, data: bus.st_data, pc: bus.st_pc};
                valid[tail] <= 1'b1;
                tail        <= tail + PTRW'(1);
            end
            // Push and pop never target the same slot: a pop needs count>0 and a
            // same-slot push would need count==DEPTH, which blocks the push.
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic,
// all compared each cycle against a queue-based model of the buffer contents.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic reset;
    store_buffer_if bus ();

    store_buffer #(.DEPTH(DEPTH), .PTRW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs straight from the queue of pending stores.
    task automatic compare_all(input logic h, input logic lr, input logic [31:0] la);
        logic        e_empty;
        logic        e_hit;
        logic [31:0] e_data;
        e_empty = (q.size() == 0);
        e_hit   = 1'b0;
        e_data  = '0;
        if (lr) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] == la[31:2]) begin
                    e_hit  = 1'b1;
                    e_data = q[i].data;
                    break;
                end
            end
        end
        check("empty",    32'(bus.empty),    32'(e_empty));
        check("st_ready", 32'(bus.st_ready), 32'(q.size() < DEPTH));
        check("dm_we",    32'(bus.dm_we),    32'(!e_empty && !h));
        if (!e_empty) begin
            check("dm_a",   bus.dm_a,   q[0].addr);
            check("dm_din", bus.dm_din, q[0].data);
            check("dm_pc",  bus.dm_pc,  q[0].pc);
        end
        check("ld_hit",  32'(bus.ld_hit), 32'(e_hit));
        check("ld_data", bus.ld_data,     e_data);
    endtask

    // One clock: drive just after posedge, compare at negedge, advance the model at posedge.
    task automatic cycle(input logic req, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic h,
                         input logic lr, input logic [31:0] la);
        logic do_pop;
        logic do_push;
        bus.st_req  = req;
        bus.st_addr = a;
        bus.st_data = d;
        bus.st_pc   = p;
        bus.hold    = h;
        bus.ld_req  = lr;
        bus.ld_addr = la;
        @(negedge clk);
        compare_all(h, lr, la);
        @(posedge clk);
        do_pop  = (q.size() != 0) && !h;
        do_push = req && (q.size() < DEPTH);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back('{addr: a, data: d, pc: p});
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p, input logic h);
        cycle(1'b1, a, d, p, h, 1'b0, 32'h0);
    endtask

    task automatic idle(input logic h, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, h, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [31:0] la, input logic h);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, h, 1'b1, la);
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_empty"},    32'(bus.empty),    32'd1);
        check({tag, "_st_ready"}, 32'(bus.st_ready), 32'd1);
        check({tag, "_dm_we"},    32'(bus.dm_we),    32'd0);
        check({tag, "_ld_hit"},   32'(bus.ld_hit),   32'd0);
        check({tag, "_ld_data"},  bus.ld_data,       32'd0);
        check({tag, "_dm_a"},     bus.dm_a,          32'd0);
        check({tag, "_dm_din"},   bus.dm_din,        32'd0);
        check({tag, "_dm_pc"},    bus.dm_pc,         32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.st_req  = 1'b0;
        bus.st_addr = '0;
        bus.st_data = '0;
        bus.st_pc   = '0;
        bus.hold    = 1'b0;
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h0;
        #2;
        reset_outputs_check("reset");
        #6 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single store reaches memory on the edge after it is accepted.
        st(32'h10, 32'hDEADBEEF, 32'h3000, 1'b0);
        idle(1'b0, 2);

        // Fill under hold, fifth store dropped, then in-order drain.
        st(32'h0, 32'h100, 32'h4000, 1'b1);
        st(32'h4, 32'h101, 32'h4004, 1'b1);
        st(32'h8, 32'h102, 32'h4008, 1'b1);
        st(32'hC, 32'h103, 32'h400C, 1'b1);
        st(32'h14, 32'h104, 32'h4010, 1'b1);
        idle(1'b1, 1);
        idle(1'b0, 5);

        // Forwarding picks the youngest of duplicate addresses, byte offset ignored.
        st(32'h20, 32'h1, 32'h5000, 1'b1);
        st(32'h20, 32'h2, 32'h5004, 1'b1);
        ld(32'h22, 1'b1);
        ld(32'h24, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20);
        ld(32'h20, 1'b0);
        idle(1'b0, 2);

        // Pointer wrap: 3 in/3 out, then fill all 4 and drain in order.
        for (int i = 0; i < 3; i++) st(32'h40 + 32'(4*i), 32'hA0 + 32'(i), 32'h6000 + 32'(4*i), 1'b1);
        idle(1'b0, 3);
        for (int i = 0; i < 4; i++) st(32'h50 + 32'(4*i), 32'hB0 + 32'(i), 32'h6100 + 32'(4*i), 1'b1);
        idle(1'b0, 5);

        // Full with drain enabled: store rejected this cycle, accepted next.
        for (int i = 0; i < 4; i++) st(32'h60 + 32'(4*i), 32'hC0 + 32'(i), 32'h7000 + 32'(4*i), 1'b1);
        st(32'h70, 32'hCAFE, 32'h7010, 1'b0);
        st(32'h70, 32'hCAFF, 32'h7014, 1'b1);
        idle(1'b0, 6);

        // Asynchronous reset mid-cycle discards pending stores.
        st(32'h80, 32'hD0, 32'h8000, 1'b1);
        st(32'h84, 32'hD1, 32'h8004, 1'b1);
        bus.st_req  = 1'b0;
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h80;
        #3 reset = 1'b0;
        #1;
        reset_outputs_check("midreset");
        q.delete();
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0, 3);

        // Random traffic, including simultaneous store and load.
        for (int n = 0; n < 400; n++) begin
            logic        req;
            logic        h;
            logic        lr;
            logic [31:0] a;
            logic [31:0] la;
            req = ($urandom_range(0, 9) < 6);
            h   = ($urandom_range(0, 9) < 3);
            lr  = ($urandom_range(0, 1) == 1);
            a   = 32'($urandom_range(0, 15)) << 2;
            la  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            cycle(req, a, $urandom, $urandom, h, lr, la);
        end
        idle(1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
